// File: rtl/lsu_mem_unit.sv
// LSU memory stage: valid/ready request channel, variable-latency load response, registered writeback.
// Misaligned or illegal-size ops raise a one-cycle error and never reach memory.
module lsu_mem_unit #(
  parameter int XLEN           = 32,
  parameter int IMM_W          = 12,
  parameter int REG_IDX_W      = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic                 is_load,
  input  logic                 is_nop,
  input  logic [1:0]           size,
  input  logic                 is_unsigned,
  input  logic                 is_rs1_fwd,
  input  logic                 is_rs2_fwd,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [XLEN-1:0]      rs1_fwd_data,
  input  logic [XLEN-1:0]      rs2_fwd_data,
  input  logic [IMM_W-1:0]     imm,
  input  logic [REG_IDX_W-1:0] rd_idx,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_we,
  output logic [XLEN-1:0]      mem_req_addr,
  output logic [XLEN-1:0]      mem_req_wdata,
  output logic [XLEN/8-1:0]    mem_req_be,
  input  logic                 mem_rsp_valid,
  input  logic [XLEN-1:0]      mem_rsp_rdata,
  output logic                 wb_valid,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 busy,
  output logic                 misalign_err,
  output logic                 timeout_err
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [XLEN-1:0]      addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
  logic [NB-1:0]        be_q, be_d;
  logic [OFFW-1:0]      off_q, off_d;
  logic [1:0]           size_q, size_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic                 we_q, we_d, uns_q, uns_d;
  logic                 wb_valid_q, wb_valid_d, mis_q, mis_d, to_q, to_d;

  logic [XLEN-1:0] op_rs1, op_rs2, ea, wdata_sh, wdata_new, rsh, ld_val;
  logic [OFFW-1:0] off;
  logic [NB-1:0]   be_new;
  logic            illegal, expire, sgn;
  int              nbits;

  assign op_rs1   = is_rs1_fwd ? rs1_fwd_data : rs1_data;
  assign op_rs2   = is_rs2_fwd ? rs2_fwd_data : rs2_data;
  assign ea       = op_rs1 + {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  assign off      = ea[OFFW-1:0];
  assign wdata_sh = op_rs2 << {off, 3'b000};
  assign expire   = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    case (size)
      2'd0:    illegal = 1'b0;
      2'd1:    illegal = ea[0];
      2'd2:    illegal = |ea[1:0];
      default: illegal = (XLEN == 32) || (|ea[2:0]);
    endcase
  end

  always_comb begin
    be_new    = '0;
    wdata_new = '0;
    for (int i = 0; i < NB; i++) begin
      if ((i >= int'(off)) && (i < int'(off) + (1 << size))) begin
        be_new[i]          = 1'b1;
        wdata_new[8*i +: 8] = wdata_sh[8*i +: 8];
      end
    end
  end

  // Load data: lane-align to bit 0, then extend above the access width.
  assign rsh = mem_rsp_rdata >> {off_q, 3'b000};
  always_comb begin
    nbits = ((8 << size_q) > XLEN) ? XLEN : (8 << size_q);
    sgn   = !uns_q && rsh[nbits-1];
    for (int i = 0; i < XLEN; i++) ld_val[i] = (i < nbits) ? rsh[i] : sgn;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    mis_d      = 1'b0;
    to_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid && !is_nop) begin
          if (illegal) begin
            mis_d = 1'b1;
          end else begin
            addr_d  = {ea[XLEN-1:OFFW], {OFFW{1'b0}}};
            be_d    = be_new;
            wdata_d = wdata_new;
            we_d    = !is_load;
            off_d   = off;
            size_d  = size;
            uns_d   = is_unsigned;
            rd_d    = rd_idx;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A handshake in the expiring cycle still wins over the timeout.
        if (mem_req_ready) begin
          state_d = we_q ? S_IDLE : S_WAIT;
          cnt_d   = cnt_q + 32'd1;
        end else if (expire) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = ld_val;
          state_d    = S_IDLE;
        end else if (expire) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      mis_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      mis_q      <= mis_d;
      to_q       <= to_d;
    end
  end

  assign op_ready      = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_be    = be_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign misalign_err  = mis_q;
  assign timeout_err   = to_q;

endmodule
